// File: rtl/timer_pkg.sv
// Shared definitions for the timer event generator: event-mode constants and
// the elaboration-time divisor helpers.
package timer_pkg;

    localparam int EVT_PULSE = 0;
    localparam int EVT_LEVEL = 1;

    // Integer truncation is intended: the tick period is the whole-cycle floor.
    function automatic int div_of(input int clk, input int rate);
        return clk / rate;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/timer_evt_gen_btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, tick-sampled debounce shift
// and an arm flag so that each stable press yields exactly one toggle request.
module btn_debounce #(
    parameter int DEB_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    input  logic sample,
    output logic toggle_req
);

    logic                 sync_1;
    logic                 sync_2;
    logic [DEB_DEPTH-1:0] deb_sh;
    logic                 armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            deb_sh <= '0;
            armed  <= 1'b1;
        end else begin
            sync_1 <= button;
            sync_2 <= sync_1;
            if (sample) begin
                deb_sh <= {deb_sh[DEB_DEPTH-2:0], sync_2};
            end
            // Disarm even if a software write wins the enable flag this cycle.
            if (toggle_req) begin
                armed <= 1'b0;
            end else if (deb_sh == '0) begin
                armed <= 1'b1;
            end
        end
    end

    assign toggle_req = armed & (&deb_sh);

endmodule

// File: rtl/timer_evt_gen.sv
// Timer event generator: rate tick, CPU clock-enable divider, timer enable flag
// and CPU event request in pulse or level/acknowledge mode, all on clk_p.
module timer_evt_gen #(
    parameter int CLK_HZ    = 50000000,
    parameter int RATE0_HZ  = 50,
    parameter int RATE1_HZ  = 60,
    parameter int SLOW_DIV  = 22,
    parameter int DEB_DEPTH = 2,
    parameter int EVT_LEVEL = 0
) (
    input  logic clk_p,
    input  logic dclo,
    input  logic slow_en,
    input  logic rate_sel,
    input  logic timer_button,
    input  logic sw_en_we,
    input  logic sw_en_d,
    input  logic evnt_ack,
    output logic cpu_clk_ena,
    output logic tick,
    output logic evnt,
    output logic timer_status,
    output logic overrun
);

    import timer_pkg::*;

    localparam int DIV0    = div_of(CLK_HZ, RATE0_HZ);
    localparam int DIV1    = div_of(CLK_HZ, RATE1_HZ);
    localparam int DIV_MAX = max_of(DIV0, DIV1);
    localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int SCNT_W  = $clog2(SLOW_DIV);

    localparam logic [CNT_W-1:0]  LAST0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0]  LAST1 = CNT_W'(DIV1 - 1);
    localparam logic [SCNT_W-1:0] SLAST = SCNT_W'(SLOW_DIV - 1);
    localparam bit LEVEL_MODE = (EVT_LEVEL != timer_pkg::EVT_PULSE);

    logic [CNT_W-1:0]  cnt;
    logic [SCNT_W-1:0] scnt;
    logic [CNT_W-1:0]  last_sel;
    logic              toggle_req;
    logic              status_next;
    logic              evnt_next;
    logic              overrun_next;
    logic              qual_tick;

    assign last_sel = rate_sel ? LAST1 : LAST0;

    // The >= compare lets a switch to the shorter period wrap immediately.
    always_ff @(posedge clk_p) begin
        if (dclo) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= last_sel) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk_p) begin
        if (dclo || scnt == SLAST) begin
            scnt <= '0;
        end else begin
            scnt <= scnt + SCNT_W'(1);
        end
    end

    assign cpu_clk_ena = dclo | ~slow_en | (scnt == '0);

    btn_debounce #(
        .DEB_DEPTH (DEB_DEPTH)
    ) u_btn (
        .clk        (clk_p),
        .rst        (dclo),
        .button     (timer_button),
        .sample     (tick),
        .toggle_req (toggle_req)
    );

    always_comb begin
        status_next = timer_status;
        if (sw_en_we) begin
            status_next = sw_en_d;
        end else if (toggle_req) begin
            status_next = ~timer_status;
        end
    end

    assign qual_tick = tick & timer_status;

    always_comb begin
        evnt_next    = 1'b0;
        overrun_next = 1'b0;
        if (LEVEL_MODE) begin
            evnt_next    = evnt;
            overrun_next = overrun;
            // A fresh tick outranks the ack so a coincident event is not lost.
            if (!status_next) begin
                evnt_next = 1'b0;
            end else if (qual_tick) begin
                evnt_next = 1'b1;
            end else if (evnt_ack) begin
                evnt_next = 1'b0;
            end
            if (evnt_ack) begin
                overrun_next = 1'b0;
            end else if (qual_tick && evnt) begin
                overrun_next = 1'b1;
            end
        end else begin
            evnt_next = qual_tick;
        end
    end

    always_ff @(posedge clk_p) begin
        if (dclo) begin
            timer_status <= 1'b0;
            evnt         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            timer_status <= status_next;
            evnt         <= evnt_next;
            overrun      <= overrun_next;
        end
    end

endmodule

// File: tb/tb_timer_evt_gen.sv
// Scoreboard bench: a pulse-mode and a level-mode instance share stimulus; a
// behavioural model queues expected outputs that a separate monitor checks.
module tb_timer_evt_gen;

    localparam int CLK_HZ    = 1000;
    localparam int RATE0_HZ  = 50;
    localparam int RATE1_HZ  = 100;
    localparam int SLOW_DIV  = 4;
    localparam int DEB_DEPTH = 2;
    localparam int DIV0      = CLK_HZ / RATE0_HZ;
    localparam int DIV1      = CLK_HZ / RATE1_HZ;

    logic clk_p;
    logic dclo, slow_en, rate_sel, timer_button, sw_en_we, sw_en_d, evnt_ack;
    logic ena_p, tick_p, evnt_p, ts_p, ovr_p;
    logic ena_l, tick_l, evnt_l, ts_l, ovr_l;

    logic n_dclo, n_rate, n_slow, n_btn, n_we, n_wd, n_ack;

    typedef struct packed {
        bit tick; bit ena; bit ts; bit ev_p; bit ev_l; bit ov_l;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    bit done     = 0;

    // model state
    int m_age, m_slow;
    bit m_tick, m_s1, m_s2, m_armed, m_ts, m_evp, m_evl, m_ovl;
    bit m_deb[$];

    timer_evt_gen #(
        .CLK_HZ(CLK_HZ), .RATE0_HZ(RATE0_HZ), .RATE1_HZ(RATE1_HZ),
        .SLOW_DIV(SLOW_DIV), .DEB_DEPTH(DEB_DEPTH), .EVT_LEVEL(0)
    ) dut_p (
        .clk_p(clk_p), .dclo(dclo), .slow_en(slow_en), .rate_sel(rate_sel),
        .timer_button(timer_button), .sw_en_we(sw_en_we), .sw_en_d(sw_en_d),
        .evnt_ack(evnt_ack), .cpu_clk_ena(ena_p), .tick(tick_p), .evnt(evnt_p),
        .timer_status(ts_p), .overrun(ovr_p)
    );

    timer_evt_gen #(
        .CLK_HZ(CLK_HZ), .RATE0_HZ(RATE0_HZ), .RATE1_HZ(RATE1_HZ),
        .SLOW_DIV(SLOW_DIV), .DEB_DEPTH(DEB_DEPTH), .EVT_LEVEL(1)
    ) dut_l (
        .clk_p(clk_p), .dclo(dclo), .slow_en(slow_en), .rate_sel(rate_sel),
        .timer_button(timer_button), .sw_en_we(sw_en_we), .sw_en_d(sw_en_d),
        .evnt_ack(evnt_ack), .cpu_clk_ena(ena_l), .tick(tick_l), .evnt(evnt_l),
        .timer_status(ts_l), .overrun(ovr_l)
    );

    initial clk_p = 1'b1;
    always #5 clk_p = ~clk_p;

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic bit deb_all(input bit v);
        foreach (m_deb[i]) if (m_deb[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    // Advances the reference by one clk_p edge using the inputs now applied.
    task automatic model_step();
        exp_t e;
        int   div;
        bit   toggle, qual, ts_n, all0;
        if (dclo) begin
            m_age = 0; m_slow = 0; m_tick = 0; m_s1 = 0; m_s2 = 0;
            m_armed = 1; m_ts = 0; m_evp = 0; m_evl = 0; m_ovl = 0;
            m_deb.delete();
            repeat (DEB_DEPTH) m_deb.push_back(1'b0);
        end else begin
            div    = rate_sel ? DIV1 : DIV0;
            toggle = m_armed && deb_all(1'b1);
            all0   = deb_all(1'b0);
            qual   = m_tick && m_ts;
            ts_n   = sw_en_we ? sw_en_d : (toggle ? !m_ts : m_ts);
            if (evnt_ack) m_ovl = 0;
            else if (qual && m_evl) m_ovl = 1;
            if (!ts_n) m_evl = 0;
            else if (qual) m_evl = 1;
            else if (evnt_ack) m_evl = 0;
            m_evp = qual;
            if (toggle) m_armed = 0;
            else if (all0) m_armed = 1;
            if (m_tick) begin
                m_deb.push_back(m_s2);
                void'(m_deb.pop_front());
            end
            m_s2 = m_s1;
            m_s1 = timer_button;
            if (m_age >= div - 1) begin m_age = 0; m_tick = 1; end
            else begin m_age++; m_tick = 0; end
            m_slow = (m_slow + 1) % SLOW_DIV;
            m_ts = ts_n;
        end
        e.tick = m_tick;
        e.ena  = dclo || !slow_en || (m_slow == 0);
        e.ts   = m_ts;
        e.ev_p = m_evp;
        e.ev_l = m_evl;
        e.ov_l = m_ovl;
        exp_q.push_back(e);
        started = 1;
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(negedge clk_p);
            dclo = n_dclo; rate_sel = n_rate; slow_en = n_slow;
            timer_button = n_btn; sw_en_we = n_we; sw_en_d = n_wd; evnt_ack = n_ack;
            model_step();
        end
    endtask

    task automatic settle();
        @(posedge clk_p);
        #2;
    endtask

    always @(posedge clk_p) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            if (started && !done) cmp("queue_empty", 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            cmp("tick_p", tick_p, e.tick);
            cmp("tick_l", tick_l, e.tick);
            cmp("ena_p", ena_p, e.ena);
            cmp("ena_l", ena_l, e.ena);
            cmp("status_p", ts_p, e.ts);
            cmp("status_l", ts_l, e.ts);
            cmp("evnt_pulse", evnt_p, e.ev_p);
            cmp("overrun_pulse", ovr_p, 1'b0);
            cmp("evnt_level", evnt_l, e.ev_l);
            cmp("overrun_level", ovr_l, e.ov_l);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        n_dclo = 1; n_rate = 0; n_slow = 0; n_btn = 0; n_we = 0; n_wd = 0; n_ack = 0;
        dclo = 1; rate_sel = 0; slow_en = 0; timer_button = 0;
        sw_en_we = 0; sw_en_d = 0; evnt_ack = 0;
        go(3);
        settle();
        cmp("reset_tick", tick_l, 1'b0);
        cmp("reset_ena", ena_l, 1'b1);

        // rate 0: ticks on cycles 19, 39, 59 after release
        n_dclo = 0;
        go(19); settle(); cmp("tick_before_19", tick_l, 1'b0);
        go(1);  settle(); cmp("tick_19", tick_l, 1'b1);
        go(20); settle(); cmp("tick_39", tick_l, 1'b1);
        go(20); settle(); cmp("tick_59", tick_l, 1'b1);
        go(15);
        n_rate = 1;
        go(1);  settle(); cmp("tick_switch_wrap", tick_l, 1'b1);
        go(9);  settle(); cmp("tick_switch_gap", tick_l, 1'b0);
        go(1);  settle(); cmp("tick_switch_period", tick_l, 1'b1);

        n_slow = 1; go(40);
        n_slow = 0; go(10);

        // button: press toggles on, holding keeps on, release and press toggles off
        n_btn = 1; go(60); settle(); cmp("btn_toggle_on", ts_l, 1'b1);
        go(40); settle(); cmp("btn_hold", ts_l, 1'b1);
        n_btn = 0; go(40);
        n_btn = 1; go(40); settle(); cmp("btn_toggle_off", ts_l, 1'b0);
        n_btn = 0; go(40);
        n_btn = 1; go(10);
        n_btn = 0; go(40); settle(); cmp("btn_glitch", ts_l, 1'b0);

        // software write wins over a coincident button toggle
        n_btn = 1;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            go(1);
            if (m_armed && deb_all(1'b1)) found = 1;
        end
        cmp("prio_toggle_seen", found, 1'b1);
        n_we = 1; n_wd = 0; go(1); n_we = 0;
        settle(); cmp("prio_sw_over_btn", ts_l, 1'b0);
        go(40); settle(); cmp("prio_disarmed", ts_l, 1'b0);
        n_btn = 0; go(30);

        // events enabled by software
        n_we = 1; n_wd = 1; go(1); n_we = 0;
        go(30); settle();
        cmp("level_evnt_held", evnt_l, 1'b1);
        cmp("level_overrun", ovr_l, 1'b1);
        found = 0;
        for (int k = 0; k < 25 && !found; k++) begin
            go(1);
            if (m_tick) found = 1;
        end
        cmp("level_tick_seen", found, 1'b1);
        n_ack = 1; go(1); settle();
        cmp("ack_on_tick_evnt", evnt_l, 1'b1);
        cmp("ack_on_tick_overrun", ovr_l, 1'b0);
        go(1); n_ack = 0; settle();
        cmp("ack_clears_evnt", evnt_l, 1'b0);
        cmp("ack_clears_overrun", ovr_l, 1'b0);
        go(40);
        n_we = 1; n_wd = 0; go(1); n_we = 0;
        go(40);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) n_rate = ~n_rate;
            if ($urandom_range(0, 29) == 0) n_slow = ~n_slow;
            if ($urandom_range(0, 24) == 0) n_btn = ~n_btn;
            n_we   = 1'($urandom_range(0, 39) == 0);
            n_wd   = 1'($urandom_range(0, 1));
            n_ack  = 1'($urandom_range(0, 3) == 0);
            n_dclo = 1'($urandom_range(0, 299) == 0);
            go(1);
        end

        // reset in mid-period with an event and overrun pending
        n_dclo = 1; n_rate = 0; n_slow = 0; n_btn = 0; n_we = 0; n_ack = 0;
        go(2);
        n_dclo = 0; n_we = 1; n_wd = 1; go(1); n_we = 0;
        go(51); settle();
        cmp("pre_reset_evnt", evnt_l, 1'b1);
        cmp("pre_reset_overrun", ovr_l, 1'b1);
        n_dclo = 1; go(1); settle();
        cmp("mid_reset_evnt", evnt_l, 1'b0);
        cmp("mid_reset_overrun", ovr_l, 1'b0);
        cmp("mid_reset_status", ts_l, 1'b0);
        n_dclo = 0;
        go(19); settle(); cmp("post_reset_no_tick", tick_l, 1'b0);
        go(1);  settle(); cmp("post_reset_tick_19", tick_l, 1'b1);
        go(3);
        done = 1;
        repeat (3) @(posedge clk_p);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
